// File: rtl/axi_xbar_pkg.sv
// Shared constants and FSM state types for the 1-to-N AXI4 crossbar.
package axi_xbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

endpackage

// File: rtl/axi_xbar_1ton_if.sv
// Upstream AXI4 bus between the core-side arbiter (master) and the crossbar (slave).
interface axi_xbar_1ton_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              rlast;

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rid, rlast,
           awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rid, rlast,
           awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/axi_xbar_decode.sv
// Address/capability decode: one-hot select of the lowest-index hitting slave, or miss.
module axi_xbar_decode import axi_xbar_pkg::*; #(
  parameter int unsigned              N_SLV     = 3,
  parameter int unsigned              ADDR_W    = 32,
  parameter int unsigned              DATA_W    = 32,
  parameter logic [N_SLV*ADDR_W-1:0]  SLV_BASE  = '0,
  parameter logic [N_SLV*ADDR_W-1:0]  SLV_MASK  = '0,
  parameter logic [N_SLV-1:0]         SLV_BURST = '1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [N_SLV-1:0]  sel,
  output logic              miss
);

  localparam logic [2:0] FULL_SIZE = 3'($clog2(DATA_W / 8));

  logic simple;
  logic found;

  assign simple = (len == 8'd0) && (size == FULL_SIZE) && (burst == BURST_INCR);

  // The first hit decides; a non-burst slave hit by a burst is a miss, not a fallthrough.
  always_comb begin
    sel   = '0;
    miss  = 1'b1;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (!found && ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        found = 1'b1;
        if (SLV_BURST[i] || simple) begin
          sel[i] = 1'b1;
          miss   = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/axi_xbar_1ton.sv
// AXI4 1-to-N demux with internal DECERR responder; one outstanding read and write.
// Optional performance counters are compiled in with the AXI_XBAR_PERF_EN macro.
module axi_xbar_1ton import axi_xbar_pkg::*; #(
  parameter int unsigned             N_SLV     = 3,
  parameter int unsigned             ADDR_W    = 32,
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             ID_W      = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE  = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK  = '0,
  parameter logic [N_SLV-1:0]        SLV_BURST = '1
) (
  input  logic                     clock,
  input  logic                     reset,
  axi_xbar_1ton_if.slave           in,
  output logic [N_SLV-1:0]         m_arvalid,
  input  logic [N_SLV-1:0]         m_arready,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [ID_W-1:0]          m_arid,
  output logic [7:0]               m_arlen,
  output logic [2:0]               m_arsize,
  output logic [1:0]               m_arburst,
  input  logic [N_SLV-1:0]         m_rvalid,
  output logic [N_SLV-1:0]         m_rready,
  input  logic [N_SLV*DATA_W-1:0]  m_rdata,
  input  logic [N_SLV*2-1:0]       m_rresp,
  input  logic [N_SLV*ID_W-1:0]    m_rid,
  input  logic [N_SLV-1:0]         m_rlast,
  output logic [N_SLV-1:0]         m_awvalid,
  input  logic [N_SLV-1:0]         m_awready,
  output logic [ADDR_W-1:0]        m_awaddr,
  output logic [ID_W-1:0]          m_awid,
  output logic [7:0]               m_awlen,
  output logic [2:0]               m_awsize,
  output logic [1:0]               m_awburst,
  output logic [N_SLV-1:0]         m_wvalid,
  input  logic [N_SLV-1:0]         m_wready,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W/8-1:0]      m_wstrb,
  output logic                     m_wlast,
  input  logic [N_SLV-1:0]         m_bvalid,
  output logic [N_SLV-1:0]         m_bready,
  input  logic [N_SLV*2-1:0]       m_bresp,
  input  logic [N_SLV*ID_W-1:0]    m_bid,
  output logic [31:0]              perf_rd_cnt,
  output logic [31:0]              perf_wr_cnt,
  output logic [31:0]              perf_err_cnt
);

  rd_state_e rd_state, rd_next;
  wr_state_e wr_state, wr_next;

  logic [N_SLV-1:0] ar_sel, aw_sel, rd_sel, wr_sel;
  logic             ar_miss, aw_miss, rd_miss, wr_miss;
  logic [ID_W-1:0]  rd_id, wr_id;
  logic [7:0]       rd_cnt;
  logic             ar_fire, r_fire, r_last_fire, aw_fire, w_last_fire, b_fire;

  axi_xbar_decode #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK), .SLV_BURST(SLV_BURST))
    u_ar_dec (.addr(in.araddr), .len(in.arlen), .size(in.arsize), .burst(in.arburst),
              .sel(ar_sel), .miss(ar_miss));

  axi_xbar_decode #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK), .SLV_BURST(SLV_BURST))
    u_aw_dec (.addr(in.awaddr), .len(in.awlen), .size(in.awsize), .burst(in.awburst),
              .sel(aw_sel), .miss(aw_miss));

  assign m_araddr  = in.araddr;
  assign m_arid    = in.arid;
  assign m_arlen   = in.arlen;
  assign m_arsize  = in.arsize;
  assign m_arburst = in.arburst;
  assign m_awaddr  = in.awaddr;
  assign m_awid    = in.awid;
  assign m_awlen   = in.awlen;
  assign m_awsize  = in.awsize;
  assign m_awburst = in.awburst;
  assign m_wdata   = in.wdata;
  assign m_wstrb   = in.wstrb;
  assign m_wlast   = in.wlast;

  assign ar_fire     = in.arvalid & in.arready;
  assign r_fire      = in.rvalid & in.rready;
  assign r_last_fire = r_fire & in.rlast;
  assign aw_fire     = in.awvalid & in.awready;
  assign w_last_fire = in.wvalid & in.wready & in.wlast;
  assign b_fire      = in.bvalid & in.bready;

  // ---------------- read path ----------------
  always_ff @(posedge clock) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_fire)     rd_next = RD_RESP;
      RD_RESP: if (r_last_fire) rd_next = RD_IDLE;
      default:                  rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    m_arvalid  = '0;
    m_rready   = '0;
    in.arready = 1'b0;
    in.rvalid  = 1'b0;
    in.rdata   = '0;
    in.rresp   = RESP_OKAY;
    in.rid     = '0;
    in.rlast   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        m_arvalid  = ar_sel & {N_SLV{in.arvalid}};
        in.arready = ar_miss | (|(m_arready & ar_sel));
      end
      RD_RESP: begin
        if (rd_miss) begin
          in.rvalid = 1'b1;
          in.rresp  = RESP_DECERR;
          in.rid    = rd_id;
          in.rlast  = (rd_cnt == 8'd0);
        end else begin
          m_rready = rd_sel & {N_SLV{in.rready}};
          for (int unsigned i = 0; i < N_SLV; i++) begin
            if (rd_sel[i]) begin
              in.rvalid = m_rvalid[i];
              in.rdata  = m_rdata[i*DATA_W +: DATA_W];
              in.rresp  = m_rresp[i*2 +: 2];
              in.rid    = m_rid[i*ID_W +: ID_W];
              in.rlast  = m_rlast[i];
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_sel  <= '0;
      rd_miss <= 1'b0;
      rd_id   <= '0;
      rd_cnt  <= '0;
    end else if (ar_fire) begin
      rd_sel  <= ar_sel;
      rd_miss <= ar_miss;
      rd_id   <= in.arid;
      rd_cnt  <= in.arlen;
    end else if (r_fire && rd_miss) begin
      rd_cnt  <= rd_cnt - 8'd1;
    end
  end

  // ---------------- write path ----------------
  always_ff @(posedge clock) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (aw_fire)     wr_next = WR_DATA;
      WR_DATA: if (w_last_fire) wr_next = WR_RESP;
      WR_RESP: if (b_fire)      wr_next = WR_IDLE;
      default:                  wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    m_awvalid  = '0;
    m_wvalid   = '0;
    m_bready   = '0;
    in.awready = 1'b0;
    in.wready  = 1'b0;
    in.bvalid  = 1'b0;
    in.bresp   = RESP_OKAY;
    in.bid     = '0;
    case (wr_state)
      WR_IDLE: begin
        m_awvalid  = aw_sel & {N_SLV{in.awvalid}};
        in.awready = aw_miss | (|(m_awready & aw_sel));
      end
      WR_DATA: begin
        if (wr_miss) begin
          in.wready = 1'b1;
        end else begin
          m_wvalid  = wr_sel & {N_SLV{in.wvalid}};
          in.wready = |(m_wready & wr_sel);
        end
      end
      WR_RESP: begin
        if (wr_miss) begin
          in.bvalid = 1'b1;
          in.bresp  = RESP_DECERR;
          in.bid    = wr_id;
        end else begin
          m_bready = wr_sel & {N_SLV{in.bready}};
          for (int unsigned i = 0; i < N_SLV; i++) begin
            if (wr_sel[i]) begin
              in.bvalid = m_bvalid[i];
              in.bresp  = m_bresp[i*2 +: 2];
              in.bid    = m_bid[i*ID_W +: ID_W];
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_sel  <= '0;
      wr_miss <= 1'b0;
      wr_id   <= '0;
    end else if (aw_fire) begin
      wr_sel  <= aw_sel;
      wr_miss <= aw_miss;
      wr_id   <= in.awid;
    end
  end

  // ---------------- performance counters ----------------
`ifdef AXI_XBAR_PERF_EN
  logic rd_err, wr_err;
  assign rd_err = r_last_fire & in.rresp[1];
  assign wr_err = b_fire & in.bresp[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else begin
      perf_rd_cnt  <= perf_rd_cnt + 32'(r_last_fire);
      perf_wr_cnt  <= perf_wr_cnt + 32'(b_fire);
      perf_err_cnt <= perf_err_cnt + 32'(rd_err) + 32'(wr_err);
    end
  end
`else
  assign perf_rd_cnt  = '0;
  assign perf_wr_cnt  = '0;
  assign perf_err_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_xbar_1ton.sv
// Directed bench for axi_xbar_1ton: decode vector table plus multi-cycle burst/error/reset sequences.
module tb_axi_xbar_1ton;

  localparam int unsigned N = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_xbar_1ton_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0]     m_araddr, m_awaddr, m_wdata;
  logic [3:0]      m_arid, m_awid, m_wstrb;
  logic [7:0]      m_arlen, m_awlen;
  logic [2:0]      m_arsize, m_awsize;
  logic [1:0]      m_arburst, m_awburst;
  logic [N*32-1:0] m_rdata;
  logic [N*2-1:0]  m_rresp, m_bresp;
  logic [N*4-1:0]  m_rid, m_bid;
  logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic            m_wlast;
  logic [31:0]     perf_rd_cnt, perf_wr_cnt, perf_err_cnt;

  axi_xbar_1ton #(
    .N_SLV(3), .ADDR_W(32), .DATA_W(32), .ID_W(4),
    .SLV_BASE({32'h0200_0000, 32'h1000_0000, 32'h8000_0000}),
    .SLV_MASK({32'hFFFF_0000, 32'hFFFF_FFF0, 32'hF800_0000}),
    .SLV_BURST(3'b001)
  ) dut (
    .clock(clock), .reset(reset), .in(bus),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_err_cnt(perf_err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;
  int exp_err  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_perf(input string tag);
`ifdef AXI_XBAR_PERF_EN
    chk({tag, "_perf_rd"},  perf_rd_cnt,  64'(exp_rd));
    chk({tag, "_perf_wr"},  perf_wr_cnt,  64'(exp_wr));
    chk({tag, "_perf_err"}, perf_err_cnt, 64'(exp_err));
`else
    chk({tag, "_perf_rd"},  perf_rd_cnt,  64'd0);
    chk({tag, "_perf_wr"},  perf_wr_cnt,  64'd0);
    chk({tag, "_perf_err"}, perf_err_cnt, 64'd0);
`endif
  endtask

  task automatic clear_inputs();
    bus.arvalid = 0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'd1;
    bus.rready  = 0;
    bus.awvalid = 0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'd1;
    bus.wvalid  = 0; bus.wdata = '0; bus.wstrb = 4'hF; bus.wlast = 0;
    bus.bready  = 0;
    m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0; m_rid = '0; m_rlast = '0;
    m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0; m_bid = '0;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = 2'd1; bus.arvalid = 1;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awsize = 3'd2; bus.awburst = 2'd1; bus.awvalid = 1;
  endtask

  // Slave s returns n beats; the other slaves hold junk valid data that must not leak through.
  task automatic rd_hit_beats(input int s, input int n, input logic [3:0] id,
                              input logic [31:0] d0, input string tag);
    for (int b = 0; b < n; b++) begin
      m_rvalid = 3'b111;
      m_rdata  = {3{32'hDEAD_BEEF}};
      m_rdata[s*32 +: 32] = d0 + 32'(b);
      m_rresp  = 6'b111111;
      m_rresp[s*2 +: 2] = 2'b00;
      m_rid    = 12'hFFF;
      m_rid[s*4 +: 4] = id;
      m_rlast  = '0;
      m_rlast[s] = (b == n - 1);
      bus.rready = 1;
      #2;
      chk({tag, "_rvalid"}, bus.rvalid, 1'b1);
      chk({tag, "_rdata"},  bus.rdata,  d0 + 32'(b));
      chk({tag, "_rresp"},  bus.rresp,  2'b00);
      chk({tag, "_rid"},    bus.rid,    id);
      chk({tag, "_rlast"},  bus.rlast,  b == n - 1);
      chk({tag, "_m_rready"}, m_rready, 3'(1 << s));
      @(negedge clock);
    end
    m_rvalid = '0; m_rlast = '0; bus.rready = 0;
  endtask

  // Internal DECERR beats; one stall cycle on beat 1 checks the counter holds.
  task automatic rd_err_beats(input int n, input logic [3:0] id, input string tag);
    bus.rready = 1;
    for (int b = 0; b < n; b++) begin
      if (b == 1) begin
        bus.rready = 0;
        #2;
        chk({tag, "_stall_rvalid"}, bus.rvalid, 1'b1);
        chk({tag, "_stall_rlast"},  bus.rlast,  n == 2);
        @(negedge clock);
        bus.rready = 1;
      end
      #2;
      chk({tag, "_rvalid"}, bus.rvalid, 1'b1);
      chk({tag, "_rdata"},  bus.rdata,  32'd0);
      chk({tag, "_rresp"},  bus.rresp,  2'b11);
      chk({tag, "_rid"},    bus.rid,    id);
      chk({tag, "_rlast"},  bus.rlast,  b == n - 1);
      chk({tag, "_arready"}, bus.arready, 1'b0);
      chk({tag, "_m_rready"}, m_rready, 3'b000);
      @(negedge clock);
    end
    bus.rready = 0;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [2:0]  mrdy;
    logic [2:0]  exp_valid;
    logic        exp_ready;
  } vec_t;

  vec_t vt[14];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    vt[0]  = '{1'b1, 32'h8000_0010, 8'd3, 3'd2, 2'd1, 3'b001, 3'b001, 1'b1};
    vt[1]  = '{1'b1, 32'h8000_0010, 8'd3, 3'd2, 2'd1, 3'b000, 3'b001, 1'b0};
    vt[2]  = '{1'b1, 32'h8000_0010, 8'd3, 3'd2, 2'd1, 3'b110, 3'b001, 1'b0};
    vt[3]  = '{1'b1, 32'h1000_0004, 8'd0, 3'd2, 2'd1, 3'b010, 3'b010, 1'b1};
    vt[4]  = '{1'b1, 32'h1000_0004, 8'd1, 3'd2, 2'd1, 3'b010, 3'b000, 1'b1};
    vt[5]  = '{1'b1, 32'h1000_0004, 8'd0, 3'd1, 2'd1, 3'b010, 3'b000, 1'b1};
    vt[6]  = '{1'b1, 32'h1000_0004, 8'd0, 3'd2, 2'd0, 3'b010, 3'b000, 1'b1};
    vt[7]  = '{1'b1, 32'h1000_0010, 8'd0, 3'd2, 2'd1, 3'b000, 3'b000, 1'b1};
    vt[8]  = '{1'b1, 32'h0200_BFF8, 8'd0, 3'd2, 2'd1, 3'b100, 3'b100, 1'b1};
    vt[9]  = '{1'b1, 32'h0201_0000, 8'd0, 3'd2, 2'd1, 3'b111, 3'b000, 1'b1};
    vt[10] = '{1'b1, 32'h2000_0000, 8'd0, 3'd2, 2'd1, 3'b000, 3'b000, 1'b1};
    vt[11] = '{1'b1, 32'h87FF_FFFC, 8'd7, 3'd2, 2'd2, 3'b000, 3'b001, 1'b0};
    vt[12] = '{1'b1, 32'h0200_0000, 8'd0, 3'd2, 2'd1, 3'b011, 3'b100, 1'b0};
    vt[13] = '{1'b0, 32'h8000_0000, 8'd0, 3'd2, 2'd1, 3'b001, 3'b000, 1'b1};

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    #2;
    chk("rst_arready", bus.arready, 1'b1);
    chk("rst_awready", bus.awready, 1'b1);
    chk("rst_rvalid",  bus.rvalid,  1'b0);
    chk("rst_wready",  bus.wready,  1'b0);
    chk("rst_bvalid",  bus.bvalid,  1'b0);
    chk("rst_m_arvalid", m_arvalid, 3'b000);
    chk("rst_m_rready",  m_rready,  3'b000);
    chk_perf("rst");

    // Decode table: AR and AW driven identically, dropped before the edge so nothing fires.
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      bus.araddr = vt[i].addr; bus.arlen = vt[i].len; bus.arsize = vt[i].size; bus.arburst = vt[i].burst;
      bus.awaddr = vt[i].addr; bus.awlen = vt[i].len; bus.awsize = vt[i].size; bus.awburst = vt[i].burst;
      bus.arvalid = vt[i].v; bus.awvalid = vt[i].v;
      m_arready = vt[i].mrdy; m_awready = vt[i].mrdy;
      #2;
      chk($sformatf("vec%0d_m_arvalid", i), m_arvalid, vt[i].exp_valid);
      chk($sformatf("vec%0d_m_awvalid", i), m_awvalid, vt[i].exp_valid);
      chk($sformatf("vec%0d_arready", i), bus.arready, vt[i].exp_ready);
      chk($sformatf("vec%0d_awready", i), bus.awready, vt[i].exp_ready);
      bus.arvalid = 0; bus.awvalid = 0;
    end
    @(negedge clock);
    clear_inputs();

    // SRAM 4-beat read burst
    set_ar(32'h8000_0010, 4'd5, 8'd3); m_arready = 3'b001;
    #2;
    chk("s1_m_arvalid", m_arvalid, 3'b001);
    chk("s1_arready", bus.arready, 1'b1);
    @(negedge clock);
    bus.arvalid = 0; m_arready = '0;
    rd_hit_beats(0, 4, 4'd5, 32'hA000_0000, "s1");
    bus.araddr = 32'h2000_0000;
    #2;
    chk("s1_idle_arready", bus.arready, 1'b1);
    exp_rd++;
    @(negedge clock);

    // Unmapped 3-beat read: accepted at once, DECERR beats
    set_ar(32'h2000_0000, 4'd9, 8'd2); m_arready = 3'b111;
    #2;
    chk("s2_arready", bus.arready, 1'b1);
    chk("s2_m_arvalid", m_arvalid, 3'b000);
    @(negedge clock);
    bus.arvalid = 0; m_arready = '0;
    rd_err_beats(3, 4'd9, "s2");
    exp_rd++; exp_err++;

    // Burst to single-beat UART
    set_ar(32'h1000_0004, 4'd2, 8'd1); m_arready = 3'b010;
    #2;
    chk("s3_m_arvalid", m_arvalid, 3'b000);
    chk("s3_arready", bus.arready, 1'b1);
    @(negedge clock);
    bus.arvalid = 0; m_arready = '0;
    rd_err_beats(2, 4'd2, "s3");
    exp_rd++; exp_err++;

    // UART write, with early W that must be held off in IDLE
    set_aw(32'h1000_0000, 4'd3, 8'd0); m_awready = 3'b010;
    bus.wvalid = 1; bus.wdata = 32'h41; bus.wlast = 1; m_wready = 3'b010;
    #2;
    chk("s4_m_awvalid", m_awvalid, 3'b010);
    chk("s4_awready", bus.awready, 1'b1);
    chk("s4_idle_wready", bus.wready, 1'b0);
    chk("s4_idle_m_wvalid", m_wvalid, 3'b000);
    @(negedge clock);
    bus.awvalid = 0; m_awready = '0;
    #2;
    chk("s4_m_wvalid", m_wvalid, 3'b010);
    chk("s4_m_wdata", m_wdata, 32'h41);
    chk("s4_wready", bus.wready, 1'b1);
    @(negedge clock);
    bus.wvalid = 0; bus.wlast = 0; m_wready = '0;
    m_bvalid = 3'b111; m_bresp = {2'b10, 2'b00, 2'b10}; m_bid = {4'hE, 4'h3, 4'hE}; bus.bready = 1;
    #2;
    chk("s4_bvalid", bus.bvalid, 1'b1);
    chk("s4_bresp", bus.bresp, 2'b00);
    chk("s4_bid", bus.bid, 4'h3);
    chk("s4_m_bready", m_bready, 3'b010);
    @(negedge clock);
    m_bvalid = '0; bus.bready = 0;
    exp_wr++;

    // Unmapped 2-beat write absorbed
    set_aw(32'h3000_0000, 4'd7, 8'd1); m_awready = 3'b111;
    #2;
    chk("s4m_awready", bus.awready, 1'b1);
    chk("s4m_m_awvalid", m_awvalid, 3'b000);
    @(negedge clock);
    bus.awvalid = 0; m_awready = '0; m_wready = 3'b111;
    for (int b = 0; b < 2; b++) begin
      bus.wvalid = 1; bus.wlast = (b == 1);
      #2;
      chk("s4m_wready", bus.wready, 1'b1);
      chk("s4m_m_wvalid", m_wvalid, 3'b000);
      chk("s4m_early_bvalid", bus.bvalid, 1'b0);
      @(negedge clock);
    end
    bus.wvalid = 0; bus.wlast = 0; m_wready = '0; bus.bready = 1;
    #2;
    chk("s4m_bvalid", bus.bvalid, 1'b1);
    chk("s4m_bresp", bus.bresp, 2'b11);
    chk("s4m_bid", bus.bid, 4'h7);
    chk("s4m_resp_awready", bus.awready, 1'b0);
    @(negedge clock);
    bus.bready = 0;
    exp_wr++; exp_err++;

    // Concurrent SRAM read and CLINT write; R-last and B fire together
    set_ar(32'h8000_0100, 4'd1, 8'd1); m_arready = 3'b001;
    set_aw(32'h0200_4000, 4'd4, 8'd0); m_awready = 3'b100;
    #2;
    chk("s5_m_arvalid", m_arvalid, 3'b001);
    chk("s5_m_awvalid", m_awvalid, 3'b100);
    @(negedge clock);
    bus.arvalid = 0; bus.awvalid = 0; m_arready = '0; m_awready = '0;
    m_rvalid = 3'b111; m_rdata = {32'h2222_2222, 32'h1111_1111, 32'hB000_0000};
    m_rid = {4'hF, 4'hF, 4'h1}; m_rresp = '0; m_rlast = 3'b110; bus.rready = 1;
    bus.wvalid = 1; bus.wdata = 32'h55; bus.wlast = 1; m_wready = 3'b111;
    #2;
    chk("s5_rdata0", bus.rdata, 32'hB000_0000);
    chk("s5_rlast0", bus.rlast, 1'b0);
    chk("s5_m_rready0", m_rready, 3'b001);
    chk("s5_m_wvalid", m_wvalid, 3'b100);
    chk("s5_wready", bus.wready, 1'b1);
    @(negedge clock);
    bus.wvalid = 0; bus.wlast = 0; m_wready = '0;
    m_rdata[31:0] = 32'hB000_0001; m_rlast = 3'b001;
    m_bvalid = 3'b111; m_bresp = {2'b00, 2'b11, 2'b11}; m_bid = {4'h4, 4'hE, 4'hE}; bus.bready = 1;
    #2;
    chk("s5_rdata1", bus.rdata, 32'hB000_0001);
    chk("s5_rlast1", bus.rlast, 1'b1);
    chk("s5_m_rready1", m_rready, 3'b001);
    chk("s5_bvalid", bus.bvalid, 1'b1);
    chk("s5_bresp", bus.bresp, 2'b00);
    chk("s5_bid", bus.bid, 4'h4);
    chk("s5_m_bready", m_bready, 3'b100);
    @(negedge clock);
    clear_inputs();
    bus.araddr = 32'h2000_0000; bus.awaddr = 32'h2000_0000;
    #2;
    chk("s5_idle_arready", bus.arready, 1'b1);
    chk("s5_idle_awready", bus.awready, 1'b1);
    exp_rd++; exp_wr++;
    @(negedge clock);

    // Read and write DECERR completing in the same cycle
    set_ar(32'h2000_0000, 4'd6, 8'd0);
    set_aw(32'h2000_0000, 4'd6, 8'd0);
    @(negedge clock);
    bus.arvalid = 0; bus.awvalid = 0;
    bus.wvalid = 1; bus.wlast = 1;
    #2;
    chk("s5e_held_rvalid", bus.rvalid, 1'b1);
    @(negedge clock);
    bus.wvalid = 0; bus.wlast = 0; bus.rready = 1; bus.bready = 1;
    #2;
    chk("s5e_rlast", bus.rlast, 1'b1);
    chk("s5e_rresp", bus.rresp, 2'b11);
    chk("s5e_bvalid", bus.bvalid, 1'b1);
    chk("s5e_bresp", bus.bresp, 2'b11);
    @(negedge clock);
    bus.rready = 0; bus.bready = 0;
    exp_rd++; exp_wr++; exp_err += 2;
    #2;
    chk_perf("pre_rst");

    // Reset in the middle of an SRAM burst
    @(negedge clock);
    set_ar(32'h8000_0000, 4'd2, 8'd3); m_arready = 3'b001;
    @(negedge clock);
    bus.arvalid = 0; m_arready = '0;
    m_rvalid = 3'b001; m_rdata = {64'h0, 32'hC000_0000}; m_rid = 12'h002; bus.rready = 1;
    #2;
    chk("s6_beat1_rvalid", bus.rvalid, 1'b1);
    @(negedge clock);
    m_rdata[31:0] = 32'hC000_0001; reset = 1;
    @(negedge clock);
    reset = 0;
    #2;
    chk("s6_rvalid", bus.rvalid, 1'b0);
    chk("s6_m_rready", m_rready, 3'b000);
    chk("s6_arready_busy_slave", bus.arready, 1'b0);
    m_arready = 3'b001;
    #1;
    chk("s6_arready_slave", bus.arready, 1'b1);
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    chk_perf("post_rst");
    @(negedge clock);
    clear_inputs();
    set_ar(32'h2000_0000, 4'd1, 8'd0);
    #2;
    chk("s6_new_arready", bus.arready, 1'b1);
    @(negedge clock);
    bus.arvalid = 0;
    rd_err_beats(1, 4'd1, "s6n");
    exp_rd++; exp_err++;
    #2;
    chk_perf("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
